// File: rtl/m_sequence_checker_if.sv
// Bit-stream and status bundle for the M-sequence checker.
//   master: drives bit_en / data_i / clear, observes the status outputs.
//   slave : the checker itself.
// Signals:
//   bit_en        one-cycle strobe qualifying data_i
//   data_i        received bit
//   clear         synchronous clear of the statistics counters
//   locked        checker synchronised to the incoming sequence
//   bit_err       one-cycle pulse on a mismatching bit while locked
//   bit_count     bits compared while locked (saturating)
//   err_count     mismatches while locked (saturating)
//   first_err_pos bit_count value at the first mismatch (optional feature)
interface m_sequence_checker_if;
  logic        bit_en;
  logic        data_i;
  logic        clear;
  logic        locked;
  logic        bit_err;
  logic [31:0] bit_count;
  logic [31:0] err_count;
  logic [31:0] first_err_pos;

  modport master (
    output bit_en, data_i, clear,
    input  locked, bit_err, bit_count, err_count, first_err_pos
  );

  modport slave (
    input  bit_en, data_i, clear,
    output locked, bit_err, bit_count, err_count, first_err_pos
  );
endinterface

// File: rtl/m_sequence_checker.sv
// M-sequence checker: self-synchronises a local LFSR to a received PRBS
// stream, then counts compared bits and bit errors for a live BER reading.
// Ports:
//   clk   receiver clock
//   reset asynchronous, active-high reset
//   bus   m_sequence_checker_if.slave (bit_en, data_i, clear in;
//         locked, bit_err, bit_count, err_count, first_err_pos out)
// Optional feature macro: MSC_FIRST_ERR_EN enables first_err_pos capture;
// when undefined first_err_pos reads 0.
module m_sequence_checker #(
  parameter int unsigned         MWIDTH      = 7,
  parameter logic [MWIDTH-1:0]   POLY        = 7'b1100000,
  parameter int unsigned         LOCK_COUNT  = 16,
  parameter int unsigned         WINDOW      = 64,
  parameter int unsigned         UNLOCK_ERRS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  m_sequence_checker_if.slave   bus
);

  localparam int unsigned LW  = $clog2(MWIDTH > 1 ? MWIDTH : 2);
  localparam int unsigned MCW = $clog2(LOCK_COUNT > 1 ? LOCK_COUNT : 2);
  localparam int unsigned WCW = $clog2(WINDOW > 1 ? WINDOW : 2);
  localparam int unsigned WEW = $clog2(UNLOCK_ERRS > 1 ? UNLOCK_ERRS : 2);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t            state;
  logic [MWIDTH-1:0] s;
  logic [LW-1:0]     load_cnt;
  logic [MCW-1:0]    match_cnt;
  logic [WCW-1:0]    win_cnt;
  logic [WEW-1:0]    win_err;
  logic              locked_q;
  logic              bit_err_q;
  logic [31:0]       bit_count_q;
  logic [31:0]       err_count_q;

  // Predicted bit, received-bit shift and mismatch flag
  logic              pred;
  logic [MWIDTH-1:0] s_rx;
  logic              miss;
  logic              lock_entry;
  logic              locked_miss;

  assign pred        = ^(s & POLY);
  assign s_rx        = {s[MWIDTH-2:0], bus.data_i};
  assign miss        = bus.data_i ^ pred;
  assign lock_entry  = bus.bit_en && (state == VERIFY) && !miss &&
                       (match_cnt == MCW'(LOCK_COUNT - 1));
  assign locked_miss = bus.bit_en && (state == LOCKED) && miss;

  // Synchronisation FSM and statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      s           <= '0;
      load_cnt    <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      bit_err_q <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          HUNT: begin
            s <= s_rx;
            if (load_cnt == LW'(MWIDTH - 1)) begin
              load_cnt <= '0;
              // all-zero is the LFSR lock-up state, so keep hunting
              if (|s_rx) begin
                state     <= VERIFY;
                match_cnt <= '0;
              end
            end else begin
              load_cnt <= load_cnt + LW'(1);
            end
          end
          VERIFY: begin
            s <= s_rx;
            if (miss) begin
              state    <= HUNT;
              load_cnt <= '0;
            end else if (match_cnt == MCW'(LOCK_COUNT - 1)) begin
              state     <= LOCKED;
              locked_q  <= 1'b1;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else begin
              match_cnt <= match_cnt + MCW'(1);
            end
          end
          LOCKED: begin
            // free-running: received bits never enter the register
            s <= {s[MWIDTH-2:0], pred};
            if (~&bit_count_q) bit_count_q <= bit_count_q + 32'd1;
            if (miss) begin
              bit_err_q <= 1'b1;
              if (~&err_count_q) err_count_q <= err_count_q + 32'd1;
            end
            if (miss && (win_err == WEW'(UNLOCK_ERRS - 1))) begin
              state    <= HUNT;
              locked_q <= 1'b0;
              win_cnt  <= '0;
              win_err  <= '0;
              load_cnt <= '0;
            end else if (win_cnt == WCW'(WINDOW - 1)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + WCW'(1);
              if (miss) win_err <= win_err + WEW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
      // clear overrides any increment on the same edge
      if (bus.clear) begin
        bit_count_q <= '0;
        err_count_q <= '0;
      end
    end
  end

`ifdef MSC_FIRST_ERR_EN
  logic        first_seen;
  logic [31:0] first_pos;

  // Capture pre-increment bit_count at the first mismatch since lock/clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_seen <= 1'b0;
      first_pos  <= '0;
    end else begin
      if (lock_entry) begin
        first_seen <= 1'b0;
      end else if (locked_miss && !first_seen) begin
        first_seen <= 1'b1;
        first_pos  <= bit_count_q;
      end
      if (bus.clear) begin
        first_seen <= 1'b0;
        first_pos  <= '0;
      end
    end
  end

  assign bus.first_err_pos = first_pos;
`else
  logic unused_capture;
  assign unused_capture    = lock_entry ^ locked_miss;
  assign bus.first_err_pos = '0;
`endif

  assign bus.locked    = locked_q;
  assign bus.bit_err   = bit_err_q;
  assign bus.bit_count = bit_count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: doc/m_sequence_checker.md
Name: m_sequence_checker

Overview:
- Receive-side counterpart of the M-sequence generator. Takes the demodulated bit stream from the receiver and self-synchronises a local LFSR to it.
- Once locked, compares every received bit against the locally predicted bit and accumulates bit and error counts, giving a live bit-error-rate measurement of the transmitter → channel → receiver path.
- Sits after the receiver data output, in the receiver clock domain. Bits are qualified by a one-cycle strobe derived from the data-rate divider.

Parameters:
- MWIDTH, 7, LFSR degree (register length).
- POLY, 7'b1100000, feedback tap mask. Bit i set means s[i] enters the XOR. Default is x^7+x^6+1, period 127.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- WINDOW, 64, length in bits of the lock-loss observation window.
- UNLOCK_ERRS, 8, errors within one window that force loss of lock.

Ports:
- clk  input  1  receiver clock.
- reset  input  1  asynchronous, active-high reset.
- bit_en  input  1  one-cycle strobe; data_i is valid and consumed this cycle.
- data_i  input  1  received bit.
- clear  input  1  synchronous clear of bit_count / err_count / first_err_pos.
- locked  output  1  checker synchronised.
- bit_err  output  1  one-cycle pulse on a compared bit that mismatches while locked.
- bit_count  output  32  bits compared while locked; saturates at 32'hFFFFFFFF.
- err_count  output  32  mismatches while locked; saturates.
- first_err_pos  output  32  see Optional Feature.

Behaviour:
- Reset: state HUNT, s=0, load/match/window/window-error counters 0. locked, bit_err, bit_count, err_count and first_err_pos all 0.
- Prediction: p = XOR of s[i] over all i where POLY[i]=1. Matching generator emits its feedback bit each data clock.
- Only cycles with bit_en=1 advance state or counters. bit_err is forced to 0 on cycles with bit_en=0.
- HUNT:
  - s <= {s[MWIDTH-2:0], data_i}; load counter increments.
  - After MWIDTH bits loaded: go to VERIFY if s (including the new bit) is nonzero. Otherwise reset the load counter and stay in HUNT (all-zero is the LFSR lock-up state).
- VERIFY:
  - Compare data_i with p; s <= {s[MWIDTH-2:0], data_i}.
  - Match: match counter increments. On reaching LOCK_COUNT, go to LOCKED; locked rises on the same clock edge.
  - Mismatch: go to HUNT with load counter 0.
  - No counting and no bit_err in this state.
- LOCKED:
  - s <= {s[MWIDTH-2:0], p} (free-running; received bits never enter s).
  - bit_count increments; on mismatch, bit_err=1 and err_count increments. Both are registered, visible the clock after the bit_en cycle.
  - Window counter runs 0..WINDOW-1, and the window-error counter counts mismatches.
  - Window-error count reaching UNLOCK_ERRS → HUNT, locked cleared on the same edge, window counters zeroed.
  - At window wrap with fewer errors, the window-error counter resets to 0.
- Counters retain their values across lock loss and relock. Only clear or reset zeroes them.
- clear coincident with a counted bit: clear wins and counters read 0 afterwards. clear does not affect state or locked.
- Saturated counters hold at max and do not wrap.
- Reset asserted mid-operation returns everything to reset values immediately (async).

Optional Feature:
- Macro MSC_FIRST_ERR_EN.
- Defined: first_err_pos captures the bit_count value (pre-increment) of the first mismatch after lock or after the last clear, and holds it until clear or reset. A sticky internal flag blocks later captures.
- Undefined: first_err_pos is tied to 0 and the capture logic is absent.

Test Plan:
- Reset held, then released with no bit_en → locked=0, bit_err=0, bit_count=0, err_count=0, state stays HUNT.
- Clean PRBS7 seeded 7'h7F, bit_en every 8 clocks → locked rises at bit 23 (7 load + 16 verify). After a further 127 bits: bit_count=127, err_count=0.
- Locked; invert the 40th counted bit → a single bit_err pulse one clock after that strobe, err_count=1, locked stays 1. With MSC_FIRST_ERR_EN, first_err_pos=39.
- Locked; invert 8 bits within one 64-bit window → locked falls on the 8th error. Relock after 23 clean bits; err_count=8 is retained.
- Constant data_i=0 for 200 bits → never leaves HUNT, locked=0, counters 0. Also invert a bit during VERIFY → back to HUNT, lock delayed by a full reload.
- Pulse clear on the same cycle as a counted erroneous bit → bit_count=0, err_count=0 next cycle. bit_err still pulses and locked is unchanged.
